// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT output reorder path.
package fft_pkg;

    localparam int unsigned DATA_W   = 50;
    localparam int unsigned COMP_W   = 25;
    localparam int unsigned N_POINTS = 8;
    localparam int unsigned IDX_W    = 3;

    typedef struct packed {
        logic signed [COMP_W-1:0] re;
        logic signed [COMP_W-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        StFill,
        StDrain
    } state_e;

    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Butterfly-result input and stream-output signals of fft_out_reorder.
interface fft_out_reorder_if #(
    parameter int unsigned DATA_W = fft_pkg::DATA_W
) ();

    logic                       in_valid_i;
    logic [DATA_W-1:0]          in_data_i;
    logic [fft_pkg::IDX_W-1:0]  in_idx_i;
    logic                       in_ready_o;
    logic                       m_tvalid_o;
    logic [DATA_W-1:0]          m_tdata_o;
    logic                       m_tlast_o;
    logic                       m_tready_i;
    logic                       frame_done_o;
    logic                       drop_err_o;

    // Environment side: drives butterfly results and downstream ready.
    modport master (
        output in_valid_i, in_data_i, in_idx_i, m_tready_i,
        input  in_ready_o, m_tvalid_o, m_tdata_o, m_tlast_o, frame_done_o, drop_err_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_idx_i, m_tready_i,
        output in_ready_o, m_tvalid_o, m_tdata_o, m_tlast_o, frame_done_o, drop_err_o
    );

endinterface

// File: rtl/fft_cplx_round.sv
// Divide-by-8 with round-half-up on both components of a complex sample.
// Only compiled when FFT_OUT_SCALE_EN is defined.
`ifdef FFT_OUT_SCALE_EN
module fft_cplx_round
    import fft_pkg::*;
(
    input  cplx_t sample_i,
    output cplx_t sample_o
);

    // One guard bit keeps x + 4 from wrapping at the positive limit.
    function automatic logic signed [COMP_W-1:0] round_div8(input logic signed [COMP_W-1:0] x);
        logic signed [COMP_W:0] wide;
        wide = $signed({x[COMP_W-1], x}) + $signed((COMP_W+1)'(4));
        wide = wide >>> 3;
        return wide[COMP_W-1:0];
    endfunction

    always_comb begin
        sample_o    = '0;
        sample_o.re = round_div8(sample_i.re);
        sample_o.im = round_div8(sample_i.im);
    end

endmodule
`endif

// File: rtl/fft_out_reorder.sv
// Collects one frame of bit-reversed butterfly results and streams it out in natural order.
// Optional output scaling by 1/N is enabled with FFT_OUT_SCALE_EN.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W   = fft_pkg::DATA_W,
    parameter int unsigned N_POINTS = fft_pkg::N_POINTS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fft_out_reorder_if.slave  bus
);

    cplx_t               buf_q [N_POINTS];
    logic [N_POINTS-1:0] mask_q;
    logic [N_POINTS-1:0] mask_d;
    logic [IDX_W-1:0]    k_q;
    state_e              state_q;
    logic                in_ready_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic                drop_err_q;

    logic                wr_en;
    logic                hs;
    cplx_t               rd_sample;
    cplx_t               out_sample;

    assign wr_en = bus.in_valid_i && in_ready_q;
    assign hs    = tvalid_q && bus.m_tready_i;

    // A repeated index re-sets an already-set bit, so duplicates never complete a frame.
    always_comb begin
        mask_d = mask_q;
        mask_d[bus.in_idx_i] = 1'b1;
    end

    // Sample storage carries no reset; the mask alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            buf_q[bus.in_idx_i] <= cplx_t'(bus.in_data_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StFill;
            mask_q     <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b1;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            if (bus.in_valid_i && !in_ready_q) begin
                drop_err_q <= 1'b1;
            end
            unique case (state_q)
                StFill: begin
                    if (wr_en) begin
                        mask_q <= mask_d;
                        if (&mask_d) begin
                            state_q    <= StDrain;
                            in_ready_q <= 1'b0;
                            tvalid_q   <= 1'b1;
                            tlast_q    <= 1'b0;
                            k_q        <= '0;
                        end
                    end
                end
                StDrain: begin
                    if (hs) begin
                        if (tlast_q) begin
                            state_q    <= StFill;
                            mask_q     <= '0;
                            k_q        <= '0;
                            in_ready_q <= 1'b1;
                            tvalid_q   <= 1'b0;
                            tlast_q    <= 1'b0;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            tlast_q <= (k_q == IDX_W'(N_POINTS - 2));
                        end
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    assign rd_sample = buf_q[bitrev3(k_q)];

`ifdef FFT_OUT_SCALE_EN
    fft_cplx_round u_round (
        .sample_i (rd_sample),
        .sample_o (out_sample)
    );
`else
    assign out_sample = rd_sample;
`endif

    assign bus.in_ready_o   = in_ready_q;
    assign bus.m_tvalid_o   = tvalid_q;
    assign bus.m_tdata_o    = tvalid_q ? DATA_W'(out_sample) : '0;
    assign bus.m_tlast_o    = tlast_q;
    assign bus.frame_done_o = hs && tlast_q;
    assign bus.drop_err_o   = drop_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed testbench for fft_out_reorder (default and FFT_OUT_SCALE_EN builds).
module tb_fft_out_reorder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   m_re [8];
    int   m_im [8];
    int   rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_out_reorder_if #(.DATA_W(50)) bus ();

    fft_out_reorder #(.DATA_W(50), .N_POINTS(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] pk(input int re, input int im);
        logic [24:0] r;
        logic [24:0] i;
        r = re[24:0];
        i = im[24:0];
        return {r, i};
    endfunction

    function automatic int scl(input int x);
`ifdef FFT_OUT_SCALE_EN
        return (x + 4) >>> 3;
`else
        return x;
`endif
    endfunction

    function automatic logic [49:0] exp_bin(input int k);
        return pk(scl(m_re[rev_tab[k]]), scl(m_im[rev_tab[k]]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_smp(input int idx, input int re, input int im);
        bus.in_valid_i = 1'b1;
        bus.in_idx_i   = 3'(idx);
        bus.in_data_i  = pk(re, im);
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) write_smp(i, m_re[i], m_im[i]);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus.in_ready_o); end
        n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b want=0", bus.m_tvalid_o); end
        n_cmp++; if (bus.m_tlast_o !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b want=0", bus.m_tlast_o); end
        n_cmp++; if (bus.m_tdata_o !== 50'd0) begin n_fail++; $display("FAIL reset_tdata got=%h want=0", bus.m_tdata_o); end
        n_cmp++; if (bus.frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.frame_done_o); end
        n_cmp++; if (bus.drop_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b want=0", bus.drop_err_o); end
    endtask

    task automatic test_natural_order();
        int pulses;
        pulses = 0;
        bus.m_tready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_re[i] = i;
            m_im[i] = -i;
        end
        for (int i = 0; i < 8; i++) begin
            write_smp(i, m_re[i], m_im[i]);
            #1;
            n_cmp++; if (bus.m_tvalid_o !== (i == 7)) begin n_fail++; $display("FAIL nat_tvalid_fill i=%0d got=%b want=%b", i, bus.m_tvalid_o, i == 7); end
            n_cmp++; if (bus.in_ready_o !== (i != 7)) begin n_fail++; $display("FAIL nat_ready_fill i=%0d got=%b want=%b", i, bus.in_ready_o, i != 7); end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== pk(scl(rev_tab[k]), scl(-rev_tab[k]))) begin n_fail++; $display("FAIL nat_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, pk(scl(rev_tab[k]), scl(-rev_tab[k]))); end
            n_cmp++; if (bus.m_tlast_o !== (k == 7)) begin n_fail++; $display("FAIL nat_tlast k=%0d got=%b want=%b", k, bus.m_tlast_o, k == 7); end
            n_cmp++; if (bus.frame_done_o !== (k == 7)) begin n_fail++; $display("FAIL nat_done k=%0d got=%b want=%b", k, bus.frame_done_o, k == 7); end
            if (bus.frame_done_o === 1'b1) pulses++;
            tick();
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL nat_done_count got=%0d want=1", pulses); end
        n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL nat_tvalid_end got=%b want=0", bus.m_tvalid_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL nat_ready_end got=%b want=1", bus.in_ready_o); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            m_re[i] = i;
            m_im[i] = 3 * i;
        end
        bus.m_tready_i = 1'b1;
        fill_all();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                bus.m_tready_i = 1'b0;
                #1;
                for (int c = 0; c < 5; c++) begin
                    n_cmp++; if (bus.m_tdata_o !== pk(scl(6), scl(18))) begin n_fail++; $display("FAIL bp_hold_tdata c=%0d got=%h want=%h", c, bus.m_tdata_o, pk(scl(6), scl(18))); end
                    n_cmp++; if (bus.m_tlast_o !== 1'b0 || bus.m_tvalid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold_ctl c=%0d got=%b%b want=10", c, bus.m_tvalid_o, bus.m_tlast_o); end
                    n_cmp++; if (bus.frame_done_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_done c=%0d got=%b want=0", c, bus.frame_done_o); end
                    tick();
                end
                bus.m_tready_i = 1'b1;
                #1;
            end
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL bp_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            n_cmp++; if (bus.m_tlast_o !== (k == 7)) begin n_fail++; $display("FAIL bp_tlast k=%0d got=%b want=%b", k, bus.m_tlast_o, k == 7); end
            tick();
        end
        n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL bp_tvalid_end got=%b want=0", bus.m_tvalid_o); end
    endtask

    task automatic test_duplicate();
        int order [6] = '{0, 1, 3, 4, 5, 6};
        for (int i = 0; i < 8; i++) begin
            m_re[i] = i + 100;
            m_im[i] = -i;
        end
        bus.m_tready_i = 1'b1;
        write_smp(2, 10, 1);
        write_smp(2, 99, 2);
        m_re[2] = 99;
        m_im[2] = 2;
        foreach (order[j]) begin
            write_smp(order[j], m_re[order[j]], m_im[order[j]]);
            #1;
            n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL dup_early_drain idx=%0d got=%b want=0", order[j], bus.m_tvalid_o); end
        end
        write_smp(7, m_re[7], m_im[7]);
        #1;
        n_cmp++; if (bus.m_tvalid_o !== 1'b1) begin n_fail++; $display("FAIL dup_drain_start got=%b want=1", bus.m_tvalid_o); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL dup_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            tick();
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 8; i++) begin
            m_re[i] = 7 * i - 20;
            m_im[i] = i + 5;
        end
        bus.m_tready_i = 1'b1;
        fill_all();
        bus.m_tready_i = 1'b0;
        write_smp(0, 555, 555);
        #1;
        n_cmp++; if (bus.drop_err_o !== 1'b1) begin n_fail++; $display("FAIL drop_set got=%b want=1", bus.drop_err_o); end
        n_cmp++; if (bus.m_tdata_o !== exp_bin(0)) begin n_fail++; $display("FAIL drop_buf_intact got=%h want=%h", bus.m_tdata_o, exp_bin(0)); end
        bus.m_tready_i = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL drop_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            m_re[i] = 1000 - i;
            m_im[i] = -2000 + i;
        end
        fill_all();
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL drop_next_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            n_cmp++; if (bus.m_tlast_o !== (k == 7)) begin n_fail++; $display("FAIL drop_next_tlast k=%0d got=%b want=%b", k, bus.m_tlast_o, k == 7); end
            tick();
        end
        n_cmp++; if (bus.drop_err_o !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got=%b want=1", bus.drop_err_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            m_re[i] = 40 + i;
            m_im[i] = 50 - i;
        end
        bus.m_tready_i = 1'b1;
        fill_all();
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (bus.m_tdata_o !== exp_bin(5)) begin n_fail++; $display("FAIL rst_pre_tdata got=%h want=%h", bus.m_tdata_o, exp_bin(5)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid got=%b want=0", bus.m_tvalid_o); end
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=1", bus.in_ready_o); end
        n_cmp++; if (bus.m_tdata_o !== 50'd0) begin n_fail++; $display("FAIL rst_mid_tdata got=%h want=0", bus.m_tdata_o); end
        n_cmp++; if (bus.drop_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop got=%b want=0", bus.drop_err_o); end
        for (int i = 0; i < 8; i++) begin
            m_re[i] = -300 - i;
            m_im[i] = 300 + 2 * i;
        end
        for (int i = 0; i < 4; i++) write_smp(i, m_re[i], m_im[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 4; i < 8; i++) write_smp(i, m_re[i], m_im[i]);
        #1;
        n_cmp++; if (bus.m_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fill_discard got=%b want=0", bus.m_tvalid_o); end
        for (int i = 0; i < 4; i++) write_smp(i, m_re[i], m_im[i]);
        #1;
        n_cmp++; if (bus.m_tvalid_o !== 1'b1) begin n_fail++; $display("FAIL rst_fill_complete got=%b want=1", bus.m_tvalid_o); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL rst_fresh_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            tick();
        end
    endtask

    task automatic test_scale();
        logic [49:0] want0;
`ifdef FFT_OUT_SCALE_EN
        want0 = pk(3, -2);
`else
        want0 = pk(20, -20);
`endif
        m_re[0] = 20;        m_im[0] = -20;
        m_re[1] = -13;       m_im[1] = 13;
        m_re[2] = 16777215;  m_im[2] = -16777216;
        m_re[3] = 4;         m_im[3] = 3;
        for (int i = 4; i < 8; i++) begin
            m_re[i] = 11 * i;
            m_im[i] = -5 * i;
        end
        bus.m_tready_i = 1'b1;
        fill_all();
        n_cmp++; if (bus.m_tdata_o !== want0) begin n_fail++; $display("FAIL scale_bin0 got=%h want=%h", bus.m_tdata_o, want0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (bus.m_tdata_o !== exp_bin(k)) begin n_fail++; $display("FAIL scale_tdata k=%0d got=%h want=%h", k, bus.m_tdata_o, exp_bin(k)); end
            tick();
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        bus.in_idx_i   = '0;
        bus.m_tready_i = 1'b0;
        test_reset();
        test_natural_order();
        test_backpressure();
        test_duplicate();
        test_drop();
        test_reset_mid();
        test_scale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
